// File: rtl/ivmul_pkg.sv
// Shared types for the ivmul issue buffer: opcode encoding and the queued micro-op payload.
package ivmul_pkg;

  // Tag field width carried in the queued payload; raise it if a wider TAG_W is used.
  localparam int unsigned IVMUL_TAG_W = 6;

  typedef enum logic [1:0] {
    IVMUL_LO  = 2'b00,
    IVMUL_HI  = 2'b01,
    IVMUL_DOT = 2'b10,
    IVMUL_ILL = 2'b11
  } ivmul_opc_e;

  typedef struct packed {
    logic [31:0]            a;
    logic [31:0]            b;
    ivmul_opc_e             opc;
    logic [IVMUL_TAG_W-1:0] tag;
  } ivmul_op_t;

endpackage

// File: rtl/ivmul_issue_if.sv
// Dispatch-side enqueue port and result-bus writeback port of the ivmul issue block.
interface ivmul_issue_if #(
  parameter int unsigned TAG_W = 6
) ();

  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_a;
  logic [31:0]      enq_b;
  logic [1:0]       enq_opc;
  logic [TAG_W-1:0] enq_tag;

  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_exc;

  logic             busy;

  modport master (
    output enq_valid, enq_a, enq_b, enq_opc, enq_tag, wb_ready,
    input  enq_ready, wb_valid, wb_data, wb_tag, wb_exc, busy
  );

  modport slave (
    input  enq_valid, enq_a, enq_b, enq_opc, enq_tag, wb_ready,
    output enq_ready, wb_valid, wb_data, wb_tag, wb_exc, busy
  );

endinterface

// File: rtl/ivmul.sv
// Packed 2x16-bit signed SIMD multiplier: low halves, high halves or dot-sum of lane products.
module ivmul
  import ivmul_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  ivmul_opc_e  opc_i,
  output logic [31:0] res_o,
  output logic        exc_o
);

  logic signed [31:0] a0, a1, b0, b1;
  logic signed [31:0] p0, p1;

  // Lanes are sign-extended to 32 bits so the truncated product is exact.
  always_comb begin
    a0 = {{16{a_i[15]}}, a_i[15:0]};
    a1 = {{16{a_i[31]}}, a_i[31:16]};
    b0 = {{16{b_i[15]}}, b_i[15:0]};
    b1 = {{16{b_i[31]}}, b_i[31:16]};
    p0 = a0 * b0;
    p1 = a1 * b1;
  end

  always_comb begin
    res_o = '0;
    exc_o = 1'b0;
    unique case (opc_i)
      IVMUL_LO:  res_o = {p1[15:0], p0[15:0]};
      IVMUL_HI:  res_o = {p1[31:16], p0[31:16]};
      IVMUL_DOT: res_o = p0 + p1;
      IVMUL_ILL: exc_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ivmul_iq_fifo.sv
// Micro-op queue with wrap-bit pointers; flush empties it on the next edge.
module ivmul_iq_fifo
  import ivmul_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      push_i,
  input  ivmul_op_t wdata_i,
  input  logic      pop_i,
  output ivmul_op_t rdata_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [AW:0] count_o
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  ivmul_op_t   mem_q [DEPTH];
  ivmul_op_t   mem_d [DEPTH];

  // Equal index with differing wrap bit means every slot is occupied.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i && !full_o) begin
        mem_d[wptr_q[AW-1:0]] = wdata_i;
        wptr_d                = wptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rptr_d = rptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/ivmul_issue.sv
// Issue queue -> operand register (S1) -> ivmul -> writeback register (S2), with flush.
module ivmul_issue
  import ivmul_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic         cpu_clock_i,
  input  logic         cpu_resetn_i,
  input  logic         flush_i,
  ivmul_issue_if.slave issue_io
);

  localparam int unsigned AW = $clog2(DEPTH);

  ivmul_op_t   fifo_wdata, fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  ivmul_opc_e       s1_opc_q, s1_opc_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_exc_q, s2_exc_d;

  logic        enq_ready, enq_fire;
  logic        s1_adv, s1_load, wb_fire;
  logic [31:0] mul_res;
  logic        mul_exc;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign enq_ready = !fifo_full && !flush_i;
  assign enq_fire  = issue_io.enq_valid && enq_ready;
  assign s1_adv    = s1_valid_q && (!s2_valid_q || issue_io.wb_ready);
  assign s1_load   = !fifo_empty && (!s1_valid_q || s1_adv);
  assign wb_fire   = s2_valid_q && issue_io.wb_ready;

  always_comb begin
    fifo_wdata     = '0;
    fifo_wdata.a   = issue_io.enq_a;
    fifo_wdata.b   = issue_io.enq_b;
    fifo_wdata.opc = ivmul_opc_e'(issue_io.enq_opc);
    fifo_wdata.tag = IVMUL_TAG_W'(issue_io.enq_tag);
  end

  ivmul_iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (cpu_clock_i),
    .rst_ni  (cpu_resetn_i),
    .flush_i (flush_i),
    .push_i  (enq_fire),
    .wdata_i (fifo_wdata),
    .pop_i   (s1_load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  ivmul u_ivmul (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .opc_i (s1_opc_q),
    .res_o (mul_res),
    .exc_o (mul_exc)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_opc_d   = s1_opc_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_exc_d   = s2_exc_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_d = 1'b1;
        s1_a_d     = fifo_rdata.a;
        s1_b_d     = fifo_rdata.b;
        s1_opc_d   = fifo_rdata.opc;
        s1_tag_d   = TAG_W'(fifo_rdata.tag);
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_data_d  = mul_res;
        s2_tag_d   = s1_tag_q;
        s2_exc_d   = mul_exc;
      end else if (wb_fire) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_opc_q   <= IVMUL_LO;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_exc_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_opc_q   <= s1_opc_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_exc_q   <= s2_exc_d;
    end
  end

  assign issue_io.enq_ready = enq_ready;
  assign issue_io.wb_valid  = s2_valid_q;
  assign issue_io.wb_data   = s2_data_q;
  assign issue_io.wb_tag    = s2_tag_q;
  assign issue_io.wb_exc    = s2_exc_q;
  assign issue_io.busy      = (fifo_count != '0) || s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_ivmul_issue.sv
// Scoreboard bench for ivmul_issue: accepted ops push model results, a monitor pops on writeback.
module tb_ivmul_issue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  ivmul_issue_if #(.TAG_W(TAG_W)) bus ();

  ivmul_issue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .cpu_clock_i  (clk),
    .cpu_resetn_i (rst_n),
    .flush_i      (flush),
    .issue_io     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_enq    = 0;
  int   t0;
  int   base;
  bit   done;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: lane products as plain integers, then select/sum per opcode.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] opc, input logic [TAG_W-1:0] tag);
    exp_t        e;
    shortint     sa0, sa1, sb0, sb1;
    longint      p0, p1;
    logic [63:0] d;
    sa0 = a[15:0];
    sa1 = a[31:16];
    sb0 = b[15:0];
    sb1 = b[31:16];
    p0  = longint'(sa0) * longint'(sb0);
    p1  = longint'(sa1) * longint'(sb1);
    d   = '0;
    e.exc = 1'b0;
    case (opc)
      2'd0: d = ((p1 & 'hFFFF) << 16) | (p0 & 'hFFFF);
      2'd1: d = (((p1 >>> 16) & 'hFFFF) << 16) | ((p0 >>> 16) & 'hFFFF);
      2'd2: d = (p0 + p1) & 'hFFFFFFFF;
      default: e.exc = 1'b1;
    endcase
    e.data = d[31:0];
    e.tag  = tag;
    return e;
  endfunction

  // Input side: every accepted op pushes its expected result; flush discards them all.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) exp_q.delete();
      else if (bus.enq_valid && bus.enq_ready) begin
        exp_q.push_back(model(bus.enq_a, bus.enq_b, bus.enq_opc, bus.enq_tag));
        n_enq <= n_enq + 1;
      end
    end
  end

  logic             hold_v;
  logic [38:0]      held;

  // Output side: compare on each writeback handshake and check held results stay put.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v)
        check("wb_stable", {bus.wb_valid, bus.wb_exc, bus.wb_tag, bus.wb_data} == {1'b1, held},
              {bus.wb_valid, bus.wb_exc, bus.wb_tag, bus.wb_data}, {1'b1, held});
      if (bus.wb_valid && bus.wb_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1'b0, {bus.wb_exc, bus.wb_tag, bus.wb_data}, '0);
        end else begin
          check("wb_result",
                {bus.wb_exc, bus.wb_tag, bus.wb_data} == {exp_q[0].exc, exp_q[0].tag, exp_q[0].data},
                {bus.wb_exc, bus.wb_tag, bus.wb_data}, {exp_q[0].exc, exp_q[0].tag, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end
      hold_v <= bus.wb_valid && !bus.wb_ready && !flush;
      held   <= {bus.wb_exc, bus.wb_tag, bus.wb_data};
    end else begin
      hold_v <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    bus.enq_valid = 1'b1;
    bus.enq_a     = a;
    bus.enq_b     = b;
    bus.enq_opc   = opc;
    bus.enq_tag   = tag;
    @(negedge clk);
    while (!bus.enq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("enq_timeout", 1'b0, 0, 1);
    step();
    bus.enq_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 300, exp_q.size(), 0);
    step();
  endtask

  // Watches for the first writeback after an op offered from idle at cycle t0.
  task automatic watch_latency(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, (cyc - t0) == 3, cyc - t0, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_a     = '0;
    bus.enq_b     = '0;
    bus.enq_opc   = '0;
    bus.enq_tag   = '0;
    bus.wb_ready  = 1'b1;

    // Reset values
    @(posedge clk);
    #2;
    check("rst_wb_valid", bus.wb_valid == 1'b0, bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data == 32'h0, bus.wb_data, 0);
    check("rst_wb_tag", bus.wb_tag == '0, bus.wb_tag, 0);
    check("rst_wb_exc", bus.wb_exc == 1'b0, bus.wb_exc, 0);
    check("rst_busy", bus.busy == 1'b0, bus.busy, 0);
    #4 rst_n = 1'b1;
    step();
    check("rst_enq_ready", bus.enq_ready == 1'b1, bus.enq_ready, 1);

    // Lane products, back-to-back, with first-result latency
    t0 = cyc;
    fork
      begin
        send(32'h0003FFFF, 32'h00050002, 2'b00, 6'h01);
        send(32'h0003FFFF, 32'h00050002, 2'b01, 6'h02);
        send(32'h0003FFFF, 32'h00050002, 2'b10, 6'h03);
      end
      watch_latency("lane_latency");
    join
    wait_idle("lane_drain");

    // Wrap-around corner
    send(32'h80008000, 32'h80008000, 2'b10, 6'h04);
    send(32'h80008000, 32'h80008000, 2'b01, 6'h05);
    send(32'h80008000, 32'h80008000, 2'b00, 6'h06);
    wait_idle("wrap_drain");

    // Back-pressure: 8 offers, DEPTH+2 accepted
    bus.wb_ready = 1'b0;
    base = n_enq;
    for (int i = 0; i < 8; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_a     = $urandom;
      bus.enq_b     = $urandom;
      bus.enq_opc   = 2'($urandom_range(0, 2));
      bus.enq_tag   = TAG_W'(i + 8);
      step();
    end
    bus.enq_valid = 1'b0;
    check("bp_accepted", (n_enq - base) == DEPTH + 2, n_enq - base, DEPTH + 2);
    @(negedge clk);
    check("bp_enq_ready_low", bus.enq_ready == 1'b0, bus.enq_ready, 0);
    step();
    bus.wb_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      @(negedge clk);
      check("bp_drain_valid", bus.wb_valid == 1'b1, bus.wb_valid, 1);
    end
    @(negedge clk);
    check("bp_busy_low", {bus.busy, bus.wb_valid} == 2'b00, {bus.busy, bus.wb_valid}, 0);
    step();

    // Illegal opcode followed by a legal op
    fork
      begin
        send(32'h12345678, 32'h9ABCDEF0, 2'b11, 6'h2A);
        send(32'h00020003, 32'h00040005, 2'b00, 6'h2B);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!bus.wb_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("ill_exc", {bus.wb_exc, bus.wb_tag, bus.wb_data} == {1'b1, 6'h2A, 32'h0},
              {bus.wb_exc, bus.wb_tag, bus.wb_data}, {1'b1, 6'h2A, 32'h0});
      end
    join
    wait_idle("ill_drain");

    // Flush with FIFO, S1 and S2 occupied plus a same-cycle offer
    bus.wb_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) send($urandom, $urandom, 2'b10, TAG_W'(i + 32));
    flush         = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_tag   = 6'h3F;
    step();
    flush         = 1'b0;
    bus.enq_valid = 1'b0;
    @(negedge clk);
    check("flush_wb_valid", bus.wb_valid == 1'b0, bus.wb_valid, 0);
    check("flush_busy", bus.busy == 1'b0, bus.busy, 0);
    step();
    bus.wb_ready = 1'b1;
    send(32'h00070007, 32'h00030003, 2'b10, 6'h11);
    wait_idle("flush_drain");

    // Random ops under random result-bus back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++)
          send($urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.wb_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    bus.wb_ready = 1'b1;
    wait_idle("rand_drain");

    // Asynchronous reset with ops in flight
    bus.wb_ready = 1'b0;
    send($urandom, $urandom, 2'b00, 6'h21);
    send($urandom, $urandom, 2'b01, 6'h22);
    send($urandom, $urandom, 2'b10, 6'h23);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", bus.wb_valid == 1'b0, bus.wb_valid, 0);
    check("arst_wb_data", bus.wb_data == 32'h0, bus.wb_data, 0);
    check("arst_wb_tag", bus.wb_tag == '0, bus.wb_tag, 0);
    check("arst_wb_exc", bus.wb_exc == 1'b0, bus.wb_exc, 0);
    check("arst_busy", bus.busy == 1'b0, bus.busy, 0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    step();
    bus.wb_ready = 1'b1;
    t0 = cyc;
    fork
      send(32'h00010002, 32'h00030004, 2'b10, 6'h30);
      watch_latency("arst_latency");
    join
    wait_idle("arst_drain");

    check("queue_empty_end", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ivmul_issue.md
# ivmul_issue

Issue buffer and two-register pipeline around the packed 16-bit SIMD multiplier `ivmul`. Accepts tagged multiply micro-ops from dispatch through a valid/ready port and queues them in a small FIFO. Drives one op per cycle into a registered operand stage feeding `ivmul`, then holds each result in a writeback register until the result bus accepts it. Supports pipeline flush and back-pressure in both directions.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `TAG_W`, 6: destination/ROB tag width.

- `cpu_clock_i` in 1: clock, rising edge.
- `cpu_resetn_i` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous kill of all in-flight ops.
- `enq_valid_i` in 1: dispatch offers an op.
- `enq_ready_o` out 1: buffer can accept.
- `enq_a_i` in 32: operand A, two packed signed 16-bit lanes.
- `enq_b_i` in 32: operand B, two packed signed 16-bit lanes.
- `enq_opc_i` in 2: 00 low halves, 01 high halves, 10 dot-sum, 11 illegal.
- `enq_tag_i` in TAG_W: destination tag.
- `wb_valid_o` out 1: result available.
- `wb_ready_i` in 1: result bus accepts.
- `wb_data_o` out 32: result.
- `wb_tag_o` out TAG_W: tag of the result.
- `wb_exc_o` out 1: op had illegal opc.
- `busy_o` out 1: any op in FIFO, S1 or S2.

## Operation
- **Enqueue.** Fires on `enq_valid_i & enq_ready_o`.
  - `enq_ready_o` is 1 when FIFO count < DEPTH and `flush_i` is 0.
  - It depends only on registered count, not on a same-cycle pop.
- **FIFO.** Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decoded from the pointer MSB.
- **S1, operand register.** Holds valid, a, b, opc, tag and drives the `ivmul` inputs.
  - S1 loads the FIFO head when the FIFO is non-empty and (S1 is empty or S1 is advancing).
- **S2, writeback register.** Holds valid, data, tag, exc.
  - S1 advances into S2 when S1 is valid and (S2 is empty or `wb_ready_i` is 1).
  - S2 holds while `wb_valid_o & ~wb_ready_i`.
- **Arithmetic.** Per lane, signed 16×16 → 32 products: P0 from bits [15:0], P1 from bits [31:16].
  - opc 00 → {P1[15:0], P0[15:0]}.
  - opc 01 → {P1[31:16], P0[31:16]}.
  - opc 10 → (P0+P1) mod 2^32. No saturation.
- **Illegal opc 11.** The op is accepted and flows normally. S2 captures data = 0 and `wb_exc_o` = 1.
- **Ordering.** Strict in-order. Tags are passed through unchanged.
- **Flush.** On the cycle `flush_i` is 1:
  - The enqueue is dropped.
  - No wb handshake is counted.
  - The next state has the FIFO empty and S1/S2 invalid.
  - Flush has priority over every other event.
- **Reset.** All valids, pointers and count go to 0; all data/tag registers go to 0. Outputs during and after reset: `enq_ready_o`=1 (once reset is released), `wb_valid_o`=0, `wb_data_o`=0, `wb_tag_o`=0, `wb_exc_o`=0, `busy_o`=0.
- **`busy_o`.** OR of FIFO non-empty, S1 valid and S2 valid.

## Timing
- **Latency.** An op enqueued at edge N into an idle block loads S1 at edge N+1 and S2 at edge N+2. `wb_valid_o` is high in the cycle after edge N+2.
- **Throughput.** One op per cycle while `wb_ready_i` stays high.
- **Back-pressure.** With `wb_ready_i` low, S2, S1 and then the FIFO fill. `enq_ready_o` drops in the cycle after the count reaches DEPTH. Maximum ops held is DEPTH+2.
- **Push and pop in the same cycle.** Count is unchanged.
- **Full.** No push occurs in a full cycle, since `enq_ready_o` is 0.
- **Stability.** `wb_data_o`, `wb_tag_o` and `wb_exc_o` stay stable while `wb_valid_o` is high and not accepted.
- **Asynchronous reset mid-operation.** All ops are discarded immediately. No partial result appears.

## Structure
- **Package `ivmul_pkg`:**
  - opc enum: `IVMUL_LO`=2'b00, `IVMUL_HI`=2'b01, `IVMUL_DOT`=2'b10, `IVMUL_ILL`=2'b11.
  - Packed struct `ivmul_op_t` with fields a, b, opc, tag. TAG_W stays a parameter, so the tag field is sized by a package localparam default.
- **Sub-modules:**
  - `ivmul_iq_fifo`: parameterised DEPTH FIFO with flush, count and full/empty.
  - `ivmul`: instantiated between S1 and S2.

## Test plan
- **Lane products.** Enqueue a=0x0003FFFF, b=0x00050002 with opc 00, 01, 10 back-to-back, `wb_ready_i`=1.
  - Results 0x000FFFFE, 0x0000FFFF, 0x0000000D, in order, tags preserved.
  - First `wb_valid_o` appears 3 edges after the first enqueue.
- **Wrap-around.** a=b=0x80008000.
  - opc 10 → 0x80000000.
  - opc 01 → 0x40004000.
  - opc 00 → 0x00000000.
- **Back-pressure.** Hold `wb_ready_i`=0 and enqueue 8 ops.
  - Exactly DEPTH+2=6 are accepted; `enq_ready_o` is 0 afterward.
  - Release `wb_ready_i`: 6 results drain in order, one per cycle, and `busy_o` falls after the last.
- **Illegal opc.** opc 11 with tag 0x2A → `wb_exc_o`=1, data 0, tag 0x2A. The next legal op is unaffected.
- **Flush.** Flush with the FIFO, S1 and S2 all occupied and a same-cycle enqueue.
  - Next cycle: `wb_valid_o`=0, `busy_o`=0.
  - The flushed-cycle op never appears.
- **Reset mid-stream.** Assert `cpu_resetn_i`=0 asynchronously between edges while ops are in flight.
  - Outputs go to reset values at once.
  - After release, a new op completes with 3-edge latency.
